// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key code width, FIFO depth, status counter
// width and the pop-control FSM encoding.
package keypad_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 3;
  // status_ctr is a fixed 2-bit port, so DEPTH may not exceed 3
  localparam int unsigned CTR_W  = 2;

  typedef enum logic {
    ARMED = 1'b0,
    HOLD  = 1'b1
  } pop_state_e;

endpackage

// File: rtl/key_code_fifo.sv
// key_code_fifo: small circular buffer holding keypad codes until the SPI
// slave has shifted them out. One entry is popped per SPI frame: the first
// transfer_done of a frame pops, later ones are ignored until the frame end
// pulse (ssbar_synced_pe) re-arms the pop logic.
//
// Optional feature: define KEY_FIFO_OVF_EN to add a sticky overflow flag.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   key_valid       1-cycle pulse, key_in holds a new key code
//   key_in          key code from keypad decoder
//   transfer_done   end-of-byte from SPI slave (may repeat within a frame)
//   ssbar_synced_pe 1-cycle pulse at SS_bar rising edge (frame end)
//   key_code        registered head entry
//   status_ctr      number of untransmitted entries (0..DEPTH)
//   full            status_ctr == DEPTH
//   ovf_clr         (KEY_FIFO_OVF_EN) clears ovf; a same-cycle drop wins
//   ovf             (KEY_FIFO_OVF_EN) set on a dropped push, sticky
module key_code_fifo #(
  parameter int unsigned DATA_W = keypad_pkg::DATA_W,
  parameter int unsigned DEPTH  = keypad_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_in,
  input  logic              transfer_done,
  input  logic              ssbar_synced_pe,
  output logic [DATA_W-1:0] key_code,
  output logic [1:0]        status_ctr,
  output logic              full
`ifdef KEY_FIFO_OVF_EN
  ,
  input  logic              ovf_clr,
  output logic              ovf
`endif
);

  import keypad_pkg::*;

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CTR_W-1:0]  r_ctr;
  logic              r_full;
  logic [DATA_W-1:0] r_key_code;
  pop_state_e        r_state;

  logic              w_pop;
  logic              w_push;
  logic [PTR_W-1:0]  w_wr_nxt;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic [CTR_W-1:0]  w_ctr_nxt;

  // Pop only on the first transfer_done of a frame and only with data.
  // A push is accepted when there is room, or when a pop frees a slot.
  always_comb begin
    w_pop  = (r_state == ARMED) && transfer_done && (r_ctr != '0);
    w_push = key_valid && (!r_full || w_pop);
  end

  // Pointer advance with wrap from DEPTH-1 to 0
  always_comb begin
    w_wr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    w_rd_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
  end

  // Occupancy update; push+pop leaves the count unchanged
  always_comb begin
    w_ctr_nxt = r_ctr;
    case ({w_push, w_pop})
      2'b10:   w_ctr_nxt = r_ctr + CTR_W'(1);
      2'b01:   w_ctr_nxt = r_ctr - CTR_W'(1);
      default: w_ctr_nxt = r_ctr;
    endcase
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= key_in;
    end
  end

  // Pointers, occupancy and full flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ctr    <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      r_ctr  <= w_ctr_nxt;
      r_full <= (w_ctr_nxt == CTR_W'(DEPTH));
    end
  end

  // Registered head. On a pop the new head may be the entry being pushed
  // this same cycle (it lands exactly where the read pointer moves to).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_code <= '0;
    end else if (w_pop) begin
      r_key_code <= (w_push && (w_rd_nxt == r_wr_ptr)) ? key_in : r_mem[w_rd_nxt];
    end else if (w_push && (r_ctr == '0)) begin
      r_key_code <= key_in;
    end
  end

  // Pop control FSM: one pop per SPI frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARMED;
    end else begin
      case (r_state)
        ARMED:   if (w_pop) r_state <= HOLD;
        HOLD:    if (ssbar_synced_pe) r_state <= ARMED;
        default: r_state <= ARMED;
      endcase
    end
  end

`ifdef KEY_FIFO_OVF_EN
  logic r_ovf;
  logic w_drop;

  assign w_drop = key_valid && !w_push;

  // Sticky overflow; a drop in the clearing cycle keeps it set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

  assign key_code   = r_key_code;
  assign status_ctr = r_ctr;
  assign full       = r_full;

endmodule

// File: tb/tb_key_code_fifo.sv
// Directed bench for key_code_fifo with a queue-based reference model and
// a per-cycle compare process, plus hand-computed literal checks.
module tb_key_code_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          key_valid = 1'b0;
  logic [DW-1:0] key_in = '0;
  logic          transfer_done = 1'b0;
  logic          ssbar_synced_pe = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [DW-1:0] key_code;
  logic [1:0]    status_ctr;
  logic          full;
  logic          ovf_o;

  int total = 0;
  int bad   = 0;

  key_code_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk             (clk),
    .rst             (rst),
    .key_valid       (key_valid),
    .key_in          (key_in),
    .transfer_done   (transfer_done),
    .ssbar_synced_pe (ssbar_synced_pe),
    .key_code        (key_code),
    .status_ctr      (status_ctr),
    .full            (full)
`ifdef KEY_FIFO_OVF_EN
    ,
    .ovf_clr         (ovf_clr),
    .ovf             (ovf_o)
`endif
  );

`ifndef KEY_FIFO_OVF_EN
  assign ovf_o = 1'b0;
`endif

  always #10 clk = ~clk;

  // Reference model: queue of pending keys, one pop per frame
  logic [DW-1:0] q[$];
  bit            m_hold = 0;
  logic [DW-1:0] m_key = '0;
  bit            m_key_known = 1;
  bit            m_ovf = 0;
  int            m_n;
  bit            m_pop, m_push, m_drop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_hold = 0;
      m_key = '0;
      m_key_known = 1;
      m_ovf = 0;
    end else begin
      m_n    = q.size();
      m_pop  = !m_hold && transfer_done && (m_n > 0);
      m_push = key_valid && ((m_n < int'(DP)) || m_pop);
      m_drop = key_valid && !m_push;
      if (m_pop) begin
        void'(q.pop_front());
        m_hold = 1;
      end else if (m_hold && ssbar_synced_pe) begin
        m_hold = 0;
      end
      if (m_push) q.push_back(key_in);
      if (m_pop) begin
        if (q.size() > 0) begin
          m_key = q[0];
          m_key_known = 1;
        end else begin
          m_key_known = 0;  // head slot holds stale data once drained
        end
      end else if (m_push && m_n == 0) begin
        m_key = key_in;
        m_key_known = 1;
      end
`ifdef KEY_FIFO_OVF_EN
      if (m_drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    chk("cyc_status_ctr", 32'(status_ctr), 32'(q.size()));
    chk("cyc_full", 32'(full), 32'(q.size() == int'(DP)));
    if (m_key_known) chk("cyc_key_code", 32'(key_code), 32'(m_key));
    chk("cyc_ovf", 32'(ovf_o), 32'(m_ovf));
  end

  // One clock of stimulus; inputs change 1 time unit after the rising edge
  task automatic cyc(input logic kv, input logic [DW-1:0] k, input logic td, input logic ss);
    key_valid = kv;
    key_in = k;
    transfer_done = td;
    ssbar_synced_pe = ss;
    @(posedge clk);
    #1;
    key_valid = 0;
    transfer_done = 0;
    ssbar_synced_pe = 0;
    ovf_clr = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  initial begin
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key_code", 32'(key_code), 32'h0);
    chk("rst_status", 32'(status_ctr), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    rst = 1;

    // single push
    cyc(1, 8'h31, 0, 0);
    chk("push1_key", 32'(key_code), 32'h31);
    chk("push1_ctr", 32'(status_ctr), 32'd1);

    // fill and overflow
    cyc(1, 8'h32, 0, 0);
    cyc(1, 8'h33, 0, 0);
    cyc(1, 8'h34, 0, 0);
    chk("fill_ctr", 32'(status_ctr), 32'd3);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_key", 32'(key_code), 32'h31);
`ifdef KEY_FIFO_OVF_EN
    chk("ovf_set", 32'(ovf_o), 32'd1);
    ovf_clr = 1;
    cyc(1, 8'h36, 0, 0);
    chk("ovf_drop_wins", 32'(ovf_o), 32'd1);
    ovf_clr = 1;
    cyc(0, 8'h00, 0, 0);
    chk("ovf_clr", 32'(ovf_o), 32'd0);
`endif

    // one pop per frame despite repeated transfer_done
    cyc(0, 8'h00, 1, 0);
    chk("pop1_key", 32'(key_code), 32'h32);
    chk("pop1_ctr", 32'(status_ctr), 32'd2);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 1);
    chk("hold_key", 32'(key_code), 32'h32);
    chk("hold_ctr", 32'(status_ctr), 32'd2);

    // push and pop together while full
    do_reset();
    cyc(1, 8'h31, 0, 0);
    cyc(1, 8'h32, 0, 0);
    cyc(1, 8'h33, 0, 0);
    cyc(1, 8'h35, 1, 0);
    chk("pp_full_ctr", 32'(status_ctr), 32'd3);
    chk("pp_full_full", 32'(full), 32'd1);
    chk("pp_full_key", 32'(key_code), 32'h32);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 1, 0);
    chk("drain_key2", 32'(key_code), 32'h33);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 1, 0);
    chk("drain_key3", 32'(key_code), 32'h35);
    chk("drain_ctr", 32'(status_ctr), 32'd1);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 1, 0);
    chk("drain_empty", 32'(status_ctr), 32'd0);
    cyc(0, 8'h00, 0, 1);

    // transfer_done on empty is ignored and the FSM stays armed
    cyc(0, 8'h00, 1, 0);
    chk("empty_td_ctr", 32'(status_ctr), 32'd0);
    cyc(1, 8'h41, 0, 0);
    chk("after_empty_key", 32'(key_code), 32'h41);
    cyc(0, 8'h00, 1, 0);
    chk("armed_pop_ctr", 32'(status_ctr), 32'd0);
    cyc(0, 8'h00, 0, 1);

    // push and pop together while empty: push only
    cyc(1, 8'h42, 1, 0);
    chk("pp_empty_ctr", 32'(status_ctr), 32'd1);
    chk("pp_empty_key", 32'(key_code), 32'h42);
    cyc(0, 8'h00, 1, 0);
    chk("pp_empty_pop", 32'(status_ctr), 32'd0);
    cyc(0, 8'h00, 0, 1);

    // asynchronous reset mid-frame
    cyc(1, 8'h51, 0, 0);
    cyc(1, 8'h52, 0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("mid_key", 32'(key_code), 32'h52);
    #4;
    rst = 0;
    #1;
    chk("async_key", 32'(key_code), 32'h0);
    chk("async_ctr", 32'(status_ctr), 32'd0);
    chk("async_full", 32'(full), 32'd0);
    chk("async_ovf", 32'(ovf_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1;
    cyc(1, 8'h61, 0, 0);
    cyc(1, 8'h62, 0, 0);
    chk("post_rst_key", 32'(key_code), 32'h61);
    cyc(0, 8'h00, 1, 0);
    chk("post_rst_pop_key", 32'(key_code), 32'h62);
    chk("post_rst_pop_ctr", 32'(status_ctr), 32'd1);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
